// File: rtl/dds_waveform_gen.sv
// dds_waveform_gen: phase-accumulator NCO for the 12-bit DAC SPI driver.
// A tick every DIV clocks advances the phase by tuning_word. The captured
// phase is mapped to a sine, square, triangle or midscale sample (offset binary).
// The sample is then presented on a valid/ready handshake with a sticky overrun flag.
// Pipeline: S1 capture -> S2 LUT read + decode -> S3 output register.
// Optional feature macro: DDS_AMPLITUDE_EN. It adds an 8-bit amplitude input and a
// fourth stage that scales the sample around midscale.
module dds_waveform_gen #(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 8,
  parameter int DIV     = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               sync_clr,
  input  logic [PHASE_W-1:0] tuning_word,
  input  logic [1:0]         wave_sel,
`ifdef DDS_AMPLITUDE_EN
  input  logic [7:0]         amplitude,
`endif
  output logic [11:0]        sample_out,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overrun
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  // Only the top phase bits feed the waveform decode: quadrant, LUT address, triangle.
  localparam int CAP_W = (LUT_AW + 2 > 13) ? (LUT_AW + 2) : 13;
  localparam int LUT_N = 1 << LUT_AW;

  // Fixed-point (Q.28) constants used to build the sine table at elaboration.
  localparam longint FX_ONE = longint'(1) << 28;
  localparam longint FX_PI  = 64'sd843314857;  // pi * 2^28

  // round(2047 * sin(pi/2 * (idx + 0.5) / LUT_N)), via a Horner-form Taylor series.
  function automatic logic [10:0] sine_entry(input int idx);
    longint x;
    longint x2;
    longint t;
    longint s;
    x  = (FX_PI * longint'(2 * idx + 1)) / longint'(4 * LUT_N);
    x2 = (x * x) >>> 28;
    t  = FX_ONE;
    for (int k = 8; k >= 1; k--) begin
      t = FX_ONE - ((x2 * t) >>> 28) / longint'((2 * k) * (2 * k + 1));
    end
    s = (x * t) >>> 28;
    return 11'((longint'(2047) * s + (FX_ONE >>> 1)) >>> 28);
  endfunction

  // NOTE: the sine table is a constant ROM, so it carries no reset; only the registers around it do.
  logic [10:0] w_lut [LUT_N];
  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    localparam logic [10:0] ENTRY = sine_entry(g);
    assign w_lut[g] = ENTRY;
  end

  // ---------------------------------------------------------------- tick
  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_cnt_last;
  logic             w_tick;

  assign w_cnt_last = (r_tick_cnt == CNT_W'(DIV - 1));
  assign w_tick     = w_cnt_last && enable;

  // Free-running sample-rate divider; keeps counting while disabled.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || w_cnt_last) r_tick_cnt <= '0;
    else                   r_tick_cnt <= r_tick_cnt + CNT_W'(1);
  end

  // ---------------------------------------------------------------- phase
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_phase_now;

  // A clear forces the phase seen this cycle to zero, so a coinciding tick
  // captures 0 and the accumulation restarts from 0 + tuning_word.
  assign w_phase_now = sync_clr ? '0 : r_phase;

  // Phase accumulator: add on tick, zero on clear, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst)           r_phase <= '0;
    else if (w_tick)   r_phase <= w_phase_now + tuning_word;
    else if (sync_clr) r_phase <= '0;
  end

  // ---------------------------------------------------------------- S1
  logic             r_s1_vld;
  logic [CAP_W-1:0] r_s1_phase;
  logic [1:0]       r_s1_wave;
`ifdef DDS_AMPLITUDE_EN
  logic [7:0]       r_s1_amp;
`endif

  // Stage 1: capture phase and waveform select together on the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_phase <= '0;
      r_s1_wave  <= 2'b00;
`ifdef DDS_AMPLITUDE_EN
      r_s1_amp   <= 8'd0;
`endif
    end else begin
      r_s1_vld <= w_tick;
      if (w_tick) begin
        r_s1_phase <= w_phase_now[PHASE_W-1 -: CAP_W];
        r_s1_wave  <= wave_sel;
`ifdef DDS_AMPLITUDE_EN
        r_s1_amp   <= amplitude;
`endif
      end
    end
  end

  // ---------------------------------------------------------------- S2
  logic [1:0]        w_quad;
  logic [LUT_AW-1:0] w_frac;
  logic [LUT_AW-1:0] w_addr;
  logic [11:0]       w_tri_raw;

  assign w_quad    = r_s1_phase[CAP_W-1 -: 2];
  assign w_frac    = r_s1_phase[CAP_W-3 -: LUT_AW];
  assign w_addr    = w_quad[0] ? ~w_frac : w_frac;
  assign w_tri_raw = r_s1_phase[CAP_W-2 -: 12];

  logic        r_s2_vld;
  logic [10:0] r_s2_lut;
  logic        r_s2_neg;
  logic [1:0]  r_s2_wave;
  logic [11:0] r_s2_tri;
  logic [11:0] r_s2_sq;
`ifdef DDS_AMPLITUDE_EN
  logic [7:0]  r_s2_amp;
`endif

  // Stage 2: registered quarter-wave LUT read plus per-waveform decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_vld  <= 1'b0;
      r_s2_lut  <= 11'd0;
      r_s2_neg  <= 1'b0;
      r_s2_wave <= 2'b00;
      r_s2_tri  <= 12'd0;
      r_s2_sq   <= 12'd0;
`ifdef DDS_AMPLITUDE_EN
      r_s2_amp  <= 8'd0;
`endif
    end else begin
      r_s2_vld  <= r_s1_vld;
      r_s2_lut  <= w_lut[w_addr];
      r_s2_neg  <= w_quad[1];
      r_s2_wave <= r_s1_wave;
      r_s2_tri  <= r_s1_phase[CAP_W-1] ? ~w_tri_raw : w_tri_raw;
      r_s2_sq   <= r_s1_phase[CAP_W-1] ? 12'h000 : 12'hFFF;
`ifdef DDS_AMPLITUDE_EN
      r_s2_amp  <= r_s1_amp;
`endif
    end
  end

  // ---------------------------------------------------------------- select
  logic [11:0] w_sample;

  // Pick the waveform captured with this sample's phase.
  // NOTE: the default is assigned first so no path leaves w_sample unassigned (no latch).
  always_comb begin
    w_sample = 12'h800;
    case (r_s2_wave)
      2'b00:   w_sample = r_s2_neg ? (12'd2047 - {1'b0, r_s2_lut})
                                   : (12'd2048 + {1'b0, r_s2_lut});
      2'b01:   w_sample = r_s2_sq;
      2'b10:   w_sample = r_s2_tri;
      default: w_sample = 12'h800;
    endcase
  end

  logic        w_load;
  logic [11:0] w_load_data;

`ifdef DDS_AMPLITUDE_EN
  logic               r_s3_vld;
  logic [11:0]        r_s3_sample;
  logic [7:0]         r_s3_amp;
  logic signed [12:0] w_diff;
  logic signed [21:0] w_prod;
  logic signed [21:0] w_scaled;

  // Stage 3 (amplitude build): hold the full-scale sample and its amplitude.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_vld    <= 1'b0;
      r_s3_sample <= 12'h800;
      r_s3_amp    <= 8'd0;
    end else begin
      r_s3_vld    <= r_s2_vld;
      r_s3_sample <= w_sample;
      r_s3_amp    <= r_s2_amp;
    end
  end

  // Scale around midscale; arithmetic shift truncates toward minus infinity.
  assign w_diff      = $signed({1'b0, r_s3_sample}) - 13'sd2048;
  assign w_prod      = 22'(w_diff) * 22'($signed({1'b0, r_s3_amp}));
  assign w_scaled    = w_prod >>> 8;
  assign w_load      = r_s3_vld;
  assign w_load_data = 12'(w_scaled + 22'sd2048);
`else
  assign w_load      = r_s2_vld;
  assign w_load_data = w_sample;
`endif

  // ---------------------------------------------------------------- output
  // Output register and handshake: a load always wins; an unconsumed sample
  // being replaced raises the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_out   <= 12'h800;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (w_load) begin
      sample_out   <= w_load_data;
      sample_valid <= 1'b1;
      if (sample_valid && !sample_ready) overrun <= 1'b1;
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dds_waveform_gen.sv
// Testbench for dds_waveform_gen (default build, full-scale output).
// Table-driven waveform vectors plus hand-written sequences for latency,
// overrun, clear/tick collision, enable fall and reset with a sample in flight.
module tb_dds_waveform_gen;

  localparam int DIV = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sync_clr;
  logic [31:0] tuning_word;
  logic [1:0]  wave_sel;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;  // posedges since the last reset release

  always #5 clk = ~clk;

  dds_waveform_gen #(.PHASE_W(32), .LUT_AW(8), .DIV(DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sync_clr     (sync_clr),
    .tuning_word  (tuning_word),
    .wave_sel     (wave_sel),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    edges++;
  endtask

  // Step until a sample is presented, within a bounded number of cycles.
  task automatic wait_sample(input string name, output logic [11:0] val);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_valid && n < 3 * DIV);
    if (!sample_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no sample within %0d cycles", name, 3 * DIV);
    end
    val = sample_out;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
    edges = 0;
  endtask

  typedef struct {
    logic        clr;
    logic [1:0]  wsel;
    logic [31:0] tw;
    int          skip;
    logic [11:0] exp;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] got;
    int          seen;

    vecs = '{
      // sine, quarter-step of 1/8 turn
      '{1'b1, 2'd0, 32'h2000_0000, 0, 12'd2054},
      '{1'b0, 2'd0, 32'h2000_0000, 0, 12'd3500},
      '{1'b0, 2'd0, 32'h2000_0000, 0, 12'd4095},
      '{1'b0, 2'd0, 32'h2000_0000, 0, 12'd3491},
      '{1'b0, 2'd0, 32'h2000_0000, 0, 12'd2041},
      '{1'b0, 2'd0, 32'h2000_0000, 0, 12'd595},
      '{1'b0, 2'd0, 32'h2000_0000, 0, 12'd0},
      '{1'b0, 2'd0, 32'h2000_0000, 0, 12'd604},
      '{1'b0, 2'd0, 32'h2000_0000, 0, 12'd2054},
      // triangle, 256-sample period
      '{1'b1, 2'd2, 32'h0100_0000, 0,   12'h000},
      '{1'b0, 2'd2, 32'h0100_0000, 0,   12'h020},
      '{1'b0, 2'd2, 32'h0100_0000, 0,   12'h040},
      '{1'b0, 2'd2, 32'h0100_0000, 124, 12'hFE0},
      '{1'b0, 2'd2, 32'h0100_0000, 0,   12'hFFF},
      '{1'b0, 2'd2, 32'h0100_0000, 0,   12'hFDF},
      '{1'b0, 2'd2, 32'h0100_0000, 125, 12'h01F},
      '{1'b0, 2'd2, 32'h0100_0000, 0,   12'h000},
      // square
      '{1'b1, 2'd1, 32'h4000_0000, 0, 12'd4095},
      '{1'b0, 2'd1, 32'h4000_0000, 0, 12'd4095},
      '{1'b0, 2'd1, 32'h4000_0000, 0, 12'd0},
      '{1'b0, 2'd1, 32'h4000_0000, 0, 12'd0},
      '{1'b0, 2'd1, 32'h4000_0000, 0, 12'd4095},
      // midscale select
      '{1'b1, 2'd3, 32'h1234_5678, 0, 12'd2048},
      '{1'b0, 2'd3, 32'h1234_5678, 0, 12'd2048}
    };

    rst = 1'b1; enable = 1'b0; sync_clr = 1'b0; sample_ready = 1'b0;
    tuning_word = '0; wave_sel = 2'd0;
    @(negedge clk);

    // ---- reset state, then idle with enable low
    rst = 1'b1;
    repeat (5) step();
    check("rst_sample_out", sample_out, 12'h800);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    edges = 0;
    seen = 0;
    repeat (DIV + 5) begin
      step();
      if (sample_valid) seen++;
    end
    check("idle_no_valid", seen, 0);
    check("idle_sample_out", sample_out, 12'h800);

    // ---- sine at quarter-turn steps, with latency from the tick
    enable = 1'b1; sample_ready = 1'b1; wave_sel = 2'd0; tuning_word = 32'h4000_0000;
    seen = 0;
    while (edges % DIV != 0) begin
      step();
      if (sample_valid) seen++;
    end
    check("pre_tick_no_valid", seen, 0);
    check("lat_s1_valid", sample_valid, 1'b0);
    step();
    check("lat_s2_valid", sample_valid, 1'b0);
    step();
    check("lat_s3_valid", sample_valid, 1'b1);
    check("sine_q0", sample_out, 12'd2054);
    wait_sample("sine_q1", got);
    check("sine_q1", got, 12'd4095);
    check("sine_q1_latency", edges % DIV, 2);
    wait_sample("sine_q2", got);
    check("sine_q2", got, 12'd2041);
    wait_sample("sine_q3", got);
    check("sine_q3", got, 12'd0);
    wait_sample("sine_wrap", got);
    check("sine_wrap", got, 12'd2054);
    check("sine_wrap_latency", edges % DIV, 2);
    step();
    check("consumed_valid_low", sample_valid, 1'b0);

    // ---- table-driven waveform vectors
    for (int i = 0; i < NV; i++) begin
      wave_sel    = vecs[i].wsel;
      tuning_word = vecs[i].tw;
      if (vecs[i].clr) begin
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
      end
      for (int s = 0; s < vecs[i].skip; s++) wait_sample($sformatf("vec%0d_skip", i), got);
      wait_sample($sformatf("vec%0d", i), got);
      check($sformatf("vec%0d_w%0d", i, vecs[i].wsel), got, vecs[i].exp);
    end

    // ---- square with back-pressure: overrun is sticky
    wave_sel = 2'd1; tuning_word = 32'h4000_0000;
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    sample_ready = 1'b0;
    wait_sample("ovr_first", got);
    check("ovr_first", got, 12'd4095);
    check("ovr_first_flag", overrun, 1'b0);
    repeat (DIV - 1) step();
    check("ovr_before_second", overrun, 1'b0);
    step();
    check("ovr_second_valid", sample_valid, 1'b1);
    check("ovr_second_flag", overrun, 1'b1);
    repeat (DIV) step();
    check("ovr_third_sample", sample_out, 12'd0);
    check("ovr_third_valid", sample_valid, 1'b1);
    sample_ready = 1'b1;
    step();
    check("ovr_drain_valid", sample_valid, 1'b0);
    check("ovr_sticky", overrun, 1'b1);

    // ---- clear coinciding with a tick: clear wins, next sample uses tuning_word
    wave_sel = 2'd2; tuning_word = 32'h1000_0000;
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    wait_sample("clr_pre", got);
    check("clr_pre", got, 12'd0);
    while (edges % DIV != DIV - 1) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    wait_sample("clr_tick", got);
    check("clr_tick_sample", got, 12'd0);
    check("clr_tick_latency", edges % DIV, 2);
    wait_sample("clr_next", got);
    check("clr_next_sample", got, 12'd512);
    wait_sample("clr_next2", got);
    check("clr_next2_sample", got, 12'd1024);

    // ---- enable fall with a sample in flight; phase frozen while disabled
    while (edges % DIV != 0) step();
    enable = 1'b0;
    wait_sample("en_fall_inflight", got);
    check("en_fall_inflight", got, 12'd1536);
    seen = 0;
    repeat (2 * DIV) begin
      step();
      if (sample_valid) seen++;
    end
    check("en_off_no_valid", seen, 0);
    enable = 1'b1;
    wait_sample("en_resume", got);
    check("en_resume_sample", got, 12'h800);

    // ---- reset one clock after a tick: pipeline flushed, phase restarts
    while (edges % DIV != 0) step();
    do_reset(1);
    check("rst_flush_valid", sample_valid, 1'b0);
    check("rst_flush_sample", sample_out, 12'h800);
    check("rst_flush_overrun", overrun, 1'b0);
    seen = 0;
    repeat (DIV + 1) begin
      step();
      if (sample_valid) seen++;
    end
    check("rst_no_stale_valid", seen, 0);
    step();
    check("rst_first_valid", sample_valid, 1'b1);
    check("rst_first_sample", sample_out, 12'd0);
    wait_sample("rst_second", got);
    check("rst_second_sample", got, 12'd512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
